// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus arbitration bundle: request/grant lines plus the address-phase handshake.
// The slave modport is the arbiter's view; the master modport is the requester/fabric view.
interface bus_arbiter_rr_if #(
   parameter int NUM_MASTERS = 4,
   parameter int ID_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
);
   logic [NUM_MASTERS-1:0] barq_i;
   logic [NUM_MASTERS-1:0] bagd_o;
   logic [ID_W-1:0]        grant_id_o;
   logic                   busy_o;
   logic                   target_ready_o;
   logic                   address_valid_i;
   logic                   data_strobe_o;
   logic                   error_o;

   modport slave (
      input  barq_i, address_valid_i,
      output bagd_o, grant_id_o, busy_o, target_ready_o, data_strobe_o, error_o
   );

   modport master (
      output barq_i, address_valid_i,
      input  bagd_o, grant_id_o, busy_o, target_ready_o, data_strobe_o, error_o
   );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Shared-bus arbiter (fixed-priority or round-robin) with address-phase timeout and data strobe.
// Grant 1 cycle after request; a grant is held until the owner drops its request line.
module bus_arbiter_rr #(
   parameter int NUM_MASTERS     = 4,
   parameter int CLK_MAX_TIMEOUT = 10,
   parameter int RR_MODE         = 1,
   parameter int ID_W            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input logic              clk,
   input logic              rst_n,
   bus_arbiter_rr_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RELEASE} state_t;

   localparam logic [7:0] TMO_LAST = 8'(CLK_MAX_TIMEOUT - 1);

   state_t                 state;
   logic [7:0]             tmo_cnt;
   logic [ID_W-1:0]        rr_ptr;
   logic [ID_W-1:0]        win;
   logic [ID_W-1:0]        next_ptr;
   logic [NUM_MASTERS-1:0] win_onehot;
   logic                   found;
   logic                   owner_req;
   int                     start;
   int                     idx;

   // Scan upward from the start index with wrap; fixed priority always starts at 0.
   always_comb begin
      start = (RR_MODE != 0) ? int'(rr_ptr) : 0;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         idx = start + i;
         if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         if (!found && bus.barq_i[idx]) begin
            win   = ID_W'(idx);
            found = 1'b1;
         end
      end
   end

   assign win_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win;
   assign next_ptr   = (int'(win) == NUM_MASTERS - 1) ? '0 : win + 1'b1;
   assign owner_req  = bus.barq_i[bus.grant_id_o];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state              <= IDLE;
         tmo_cnt            <= '0;
         rr_ptr             <= '0;
         bus.bagd_o         <= '0;
         bus.grant_id_o     <= '0;
         bus.busy_o         <= 1'b0;
         bus.target_ready_o <= 1'b0;
         bus.data_strobe_o  <= 1'b0;
         bus.error_o        <= 1'b0;
      end else begin
         bus.data_strobe_o <= 1'b0;
         bus.error_o       <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  state              <= ADDR;
                  bus.bagd_o         <= win_onehot;
                  bus.grant_id_o     <= win;
                  bus.busy_o         <= 1'b1;
                  bus.target_ready_o <= 1'b1;
                  tmo_cnt            <= '0;
                  if (RR_MODE != 0) rr_ptr <= next_ptr;
               end
            end
            ADDR: begin
               if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
               // Owner withdrawal beats a same-cycle address hit; a hit beats the timeout.
               if (!owner_req) begin
                  state              <= RELEASE;
                  bus.target_ready_o <= 1'b0;
               end else if (bus.address_valid_i) begin
                  state             <= DATA;
                  bus.data_strobe_o <= 1'b1;
               end else if (tmo_cnt == TMO_LAST) begin
                  state              <= RELEASE;
                  bus.error_o        <= 1'b1;
                  bus.target_ready_o <= 1'b0;
               end
            end
            DATA: begin
               state              <= RELEASE;
               bus.target_ready_o <= 1'b0;
            end
            RELEASE: begin
               if (!owner_req) begin
                  state          <= IDLE;
                  bus.bagd_o     <= '0;
                  bus.grant_id_o <= '0;
                  bus.busy_o     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_strobe_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.data_strobe_o && bus.error_o));
   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(bus.bagd_o));

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: a round-robin and a fixed-priority instance checked each cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_bus_arbiter_rr;
   localparam int N    = 4;
   localparam int MAXT = 10;
   localparam int IDW  = 2;
   localparam int PH_IDLE = 0, PH_ADDR = 1, PH_DATA = 2, PH_REL = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   barq [2];
   logic           av   [2];
   logic [N-1:0]   bagd [2];
   logic [IDW-1:0] gid  [2];
   logic           busy [2];
   logic           trdy [2];
   logic           strb [2];
   logic           err  [2];

   int checks = 0;
   int errors = 0;

   bus_arbiter_rr_if #(.NUM_MASTERS(N), .ID_W(IDW)) bi_rr ();
   bus_arbiter_rr_if #(.NUM_MASTERS(N), .ID_W(IDW)) bi_fp ();

   bus_arbiter_rr #(.NUM_MASTERS(N), .CLK_MAX_TIMEOUT(MAXT), .RR_MODE(1), .ID_W(IDW)) u_rr (
      .clk(clk), .rst_n(rst_n), .bus(bi_rr.slave));
   bus_arbiter_rr #(.NUM_MASTERS(N), .CLK_MAX_TIMEOUT(MAXT), .RR_MODE(0), .ID_W(IDW)) u_fp (
      .clk(clk), .rst_n(rst_n), .bus(bi_fp.slave));

   assign bi_rr.barq_i = barq[0];
   assign bi_rr.address_valid_i = av[0];
   assign bi_fp.barq_i = barq[1];
   assign bi_fp.address_valid_i = av[1];
   assign bagd[0] = bi_rr.bagd_o;  assign bagd[1] = bi_fp.bagd_o;
   assign gid[0]  = bi_rr.grant_id_o; assign gid[1] = bi_fp.grant_id_o;
   assign busy[0] = bi_rr.busy_o;  assign busy[1] = bi_fp.busy_o;
   assign trdy[0] = bi_rr.target_ready_o; assign trdy[1] = bi_fp.target_ready_o;
   assign strb[0] = bi_rr.data_strobe_o;  assign strb[1] = bi_fp.data_strobe_o;
   assign err[0]  = bi_rr.error_o; assign err[1] = bi_fp.error_o;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_phase [2];
   int m_owner [2];
   int m_wait  [2];
   int m_next  [2];
   bit m_err   [2];

   function automatic int pick(input logic [N-1:0] req, input int from);
      for (int i = 0; i < N; i++)
         if (req[(from + i) % N]) return (from + i) % N;
      return -1;
   endfunction

   task automatic model_step(input int k);
      m_err[k] = 1'b0;
      if (!rst_n) begin
         m_phase[k] = PH_IDLE; m_owner[k] = -1; m_wait[k] = 0; m_next[k] = 0;
         return;
      end
      case (m_phase[k])
         PH_IDLE: if (barq[k] != '0) begin
            m_owner[k] = pick(barq[k], (k == 0) ? m_next[k] : 0);
            m_next[k]  = (m_owner[k] + 1) % N;
            m_phase[k] = PH_ADDR;
            m_wait[k]  = 0;
         end
         PH_ADDR: begin
            if (!barq[k][m_owner[k]]) m_phase[k] = PH_REL;
            else if (av[k]) m_phase[k] = PH_DATA;
            else if (m_wait[k] + 1 >= MAXT) begin
               m_phase[k] = PH_REL;
               m_err[k]   = 1'b1;
            end
            m_wait[k] = m_wait[k] + 1;
         end
         PH_DATA: m_phase[k] = PH_REL;
         default: if (!barq[k][m_owner[k]]) begin
            m_owner[k] = -1;
            m_phase[k] = PH_IDLE;
         end
      endcase
   endtask

   initial begin
      m_phase = '{PH_IDLE, PH_IDLE}; m_owner = '{-1, -1};
      m_wait = '{0, 0}; m_next = '{0, 0}; m_err = '{1'b0, 1'b0};
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   // Cycle-by-cycle comparison on the falling edge
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d.bagd", k), 32'(bagd[k]),
                (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0);
            chk($sformatf("m%0d.grant_id", k), 32'(gid[k]),
                (m_owner[k] >= 0) ? 32'(m_owner[k]) : 32'd0);
            chk($sformatf("m%0d.busy", k), 32'(busy[k]), 32'(m_phase[k] != PH_IDLE));
            chk($sformatf("m%0d.target_ready", k), 32'(trdy[k]),
                32'(m_phase[k] == PH_ADDR || m_phase[k] == PH_DATA));
            chk($sformatf("m%0d.strobe", k), 32'(strb[k]), 32'(m_phase[k] == PH_DATA));
            chk($sformatf("m%0d.error", k), 32'(err[k]), 32'(m_err[k]));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_grant(input int k, output int id);
      id = -1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (bagd[k] != '0) begin
            id = int'(gid[k]);
            break;
         end
      end
      chk($sformatf("grant_within_budget_m%0d", k), 32'(id >= 0), 32'd1);
   endtask

   task automatic run_fairness(input int k, output int ids [5]);
      int id;
      barq[k] = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_grant(k, id);
         ids[g] = id;
         av[k] = 1'b1;
         tick(1);
         chk("fair.strobe", 32'(strb[k]), 32'd1);
         av[k] = 1'b0;
         tick(1);
         if (id >= 0) barq[k][id] = 1'b0;
         tick(1);
         chk("fair.idle", 32'(busy[k]), 32'd0);
         barq[k] = (g < 4) ? 4'b1111 : 4'b0000;
      end
   endtask

   int ids [5];
   int rr_exp [5] = '{0, 1, 2, 3, 0};

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      barq = '{4'b1111, 4'b0000};
      av   = '{1'b0, 1'b0};
      rst_n = 1'b0;
      tick(3);
      chk("rst.bagd", 32'(bagd[0]), 32'd0);
      chk("rst.busy", 32'(busy[0]), 32'd0);
      chk("rst.trdy", 32'(trdy[0]), 32'd0);
      rst_n = 1'b1;
      tick(1);
      chk("rst.first_grant", 32'(bagd[0]), 32'b0001);
      barq[0] = 4'b0000;
      tick(3);
      chk("rst.back_idle", 32'(busy[0]), 32'd0);

      // Normal transfer by master 1
      barq[0] = 4'b0010;
      tick(1);
      chk("norm.bagd", 32'(bagd[0]), 32'b0010);
      chk("norm.id", 32'(gid[0]), 32'd1);
      tick(1);
      av[0] = 1'b1;
      tick(1);
      chk("norm.strobe", 32'(strb[0]), 32'd1);
      chk("norm.err", 32'(err[0]), 32'd0);
      av[0] = 1'b0;
      tick(1);
      chk("norm.strobe_once", 32'(strb[0]), 32'd0);
      chk("norm.held", 32'(bagd[0]), 32'b0010);
      barq[0] = 4'b0000;
      tick(1);
      chk("norm.release", 32'(bagd[0]), 32'd0);

      // Address-phase timeout
      barq[0] = 4'b0001;
      tick(1);
      chk("tmo.bagd", 32'(bagd[0]), 32'b0001);
      for (int c = 1; c < MAXT; c++) begin
         tick(1);
         chk("tmo.no_early_err", 32'(err[0]), 32'd0);
      end
      tick(1);
      chk("tmo.err", 32'(err[0]), 32'd1);
      chk("tmo.no_strobe", 32'(strb[0]), 32'd0);
      chk("tmo.trdy_low", 32'(trdy[0]), 32'd0);
      tick(1);
      chk("tmo.err_once", 32'(err[0]), 32'd0);
      tick(2);
      chk("tmo.held", 32'(bagd[0]), 32'b0001);
      barq[0] = 4'b0000;
      tick(1);
      chk("tmo.release", 32'(bagd[0]), 32'd0);

      // Fairness: pointer reset first so the order starts at master 0
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      run_fairness(0, ids);
      for (int g = 0; g < 5; g++) chk($sformatf("rr.order%0d", g), 32'(ids[g]), 32'(rr_exp[g]));
      run_fairness(1, ids);
      for (int g = 0; g < 5; g++) chk($sformatf("fp.order%0d", g), 32'(ids[g]), 32'd0);

      // Abort: owner drops in the same cycle as an address hit
      barq[0] = 4'b0100;
      tick(1);
      chk("abort.id", 32'(gid[0]), 32'd2);
      tick(1);
      barq[0] = 4'b0000;
      av[0] = 1'b1;
      tick(1);
      chk("abort.no_strobe", 32'(strb[0]), 32'd0);
      chk("abort.no_err", 32'(err[0]), 32'd0);
      chk("abort.busy_rel", 32'(busy[0]), 32'd1);
      av[0] = 1'b0;
      tick(1);
      chk("abort.idle", 32'(busy[0]), 32'd0);

      // Reset during the DATA cycle
      barq[0] = 4'b1000;
      tick(1);
      chk("mrst.id", 32'(gid[0]), 32'd3);
      av[0] = 1'b1;
      tick(1);
      chk("mrst.in_data", 32'(strb[0]), 32'd1);
      rst_n = 1'b0;
      av[0] = 1'b0;
      tick(1);
      chk("mrst.strobe", 32'(strb[0]), 32'd0);
      chk("mrst.bagd", 32'(bagd[0]), 32'd0);
      rst_n = 1'b1;
      barq[0] = 4'b1111;
      tick(1);
      chk("mrst.ptr0", 32'(bagd[0]), 32'b0001);

      // Address hit on the timeout cycle: the hit wins
      barq[0] = 4'b0001;
      tick(MAXT - 1);
      av[0] = 1'b1;
      tick(1);
      chk("race.strobe", 32'(strb[0]), 32'd1);
      chk("race.no_err", 32'(err[0]), 32'd0);
      av[0] = 1'b0;
      barq[0] = 4'b0000;
      tick(3);
      chk("race.idle", 32'(busy[0]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Parametrised successor to the existing shared-bus arbiter. It arbitrates NUM_MASTERS bus requesters onto the single shared address/data bus, in either fixed-priority or round-robin mode. It runs the address-phase handshake against the slave-side address_valid, emits a one-cycle data strobe, and flags address-phase timeouts. It sits between the master request lines and the bus multiplexer/slave decode logic.

Parameters:
NUM_MASTERS, 4, number of requesters (2..16).
CLK_MAX_TIMEOUT, 10, max cycles in ADDR waiting for address_valid_i before error (1..255).
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
ID_W, $clog2(NUM_MASTERS) (min 1), width of grant_id_o.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
barq_i  in  NUM_MASTERS  bus request, one bit per master, level, held until served
bagd_o  out  NUM_MASTERS  bus grant, one-hot or zero
grant_id_o  out  ID_W  binary index of current owner, 0 when idle
busy_o  out  1  high in any state other than IDLE
target_ready_o  out  1  address phase open; slaves may decode the address
address_valid_i  in  1  OR of slave address hits (registered by the bus fabric)
data_strobe_o  out  1  one-cycle data transfer strobe
error_o  out  1  one-cycle pulse on address-phase timeout

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE. bagd_o=0, grant_id_o=0, busy_o=0, target_ready_o=0, data_strobe_o=0, error_o=0. Timeout counter=0. RR pointer=0 (master 0 has highest priority next). Reset in any state aborts the transfer immediately, with no strobe and no error.
- All outputs are registered.
- States: IDLE, ADDR, DATA, RELEASE.
- IDLE: when |barq_i, select the winner W. On the next edge: bagd_o=onehot(W), grant_id_o=W, target_ready_o=1, counter=0, go to ADDR. Latency from request to grant is 1 cycle.
- Winner selection:
  - RR_MODE=0: lowest set index.
  - RR_MODE=1: first set index scanning upward from the pointer, wrapping NUM_MASTERS-1 -> 0. The pointer becomes (W+1) mod NUM_MASTERS at grant time.
- ADDR: the counter increments each cycle.
  - If address_valid_i=1: go to DATA, with data_strobe_o=1 for exactly that next cycle.
  - Else if counter == CLK_MAX_TIMEOUT-1: error_o=1 for one cycle, target_ready_o=0, go to RELEASE, no strobe.
  - If barq_i[W] drops during ADDR: abort to RELEASE, no strobe, no error. Abort takes precedence over both address_valid_i and timeout in the same cycle.
  - address_valid_i and timeout in the same cycle: address_valid_i wins.
- DATA: lasts one cycle. data_strobe_o=1, target_ready_o stays 1. Next state is RELEASE; data_strobe_o and target_ready_o deassert.
- RELEASE: bagd_o is held until barq_i[W]=0. On that edge bagd_o=0, grant_id_o=0, go to IDLE.
  - The earliest regrant is the cycle after IDLE is entered; there are no back-to-back grants without an IDLE cycle.
  - While in RELEASE, requests from other masters are only recorded; they are arbitrated in IDLE.
- target_ready_o is high only in ADDR and DATA. data_strobe_o and error_o are never high together.
- address_valid_i is ignored outside ADDR.
- The timeout counter is 8 bits and saturates; it never wraps.

Test Plan:
1. Reset check: rst_n=0 for 3 cycles with barq_i=4'b1111 -> all outputs 0; first grant is 1 cycle after rst_n=1, bagd_o=0001.
2. Normal transfer: barq_i=0010, address_valid_i=1 two cycles into ADDR. Expect:
   - bagd_o=0010 and grant_id_o=1 one cycle after the request.
   - data_strobe_o high for exactly 1 cycle, error_o=0.
   - Grant released 1 cycle after barq_i[1] drops.
3. Timeout: barq_i=0001, address_valid_i held 0, CLK_MAX_TIMEOUT=10 -> error_o pulses exactly once, 10 cycles after bagd_o rises, with no strobe. bagd_o is held until barq_i[0]=0.
4. Round-robin fairness: RR_MODE=1, barq_i=1111 held, each owner drops barq for 1 cycle after its strobe -> grant order 0,1,2,3,0. RR_MODE=0 with the same stimulus -> grant stays with master 0 on every regrant.
5. Abort: barq_i[2] drops in the same cycle address_valid_i=1 during ADDR -> no strobe, no error, IDLE two cycles later.
6. Mid-operation reset: rst_n=0 in the DATA cycle -> data_strobe_o=0, bagd_o=0 on the next edge, RR pointer=0.
